bitops_bit_iter: RTL and testbench

BITOPS_BIT_ITER -- requirements
Module: bitops_bit_iter

---
 rtl/bitops_pkg.sv | 13 +
 rtl/bitops_prio_pick.sv | 43 ++++
 rtl/bitops_bit_iter.sv | 122 ++++++++++++
 tb/tb_bitops_bit_iter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bitops_pkg.sv
// rtl/bitops_pkg.sv - shared state type and scan-order constants for the bitops blocks
package bitops_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Scan order select: highest set bit first or lowest set bit first.
  localparam logic MODE_HI = 1'b0;
  localparam logic MODE_LO = 1'b1;

endpackage

// File: rtl/bitops_prio_pick.sv
// rtl/bitops_prio_pick.sv - combinational priority pick of the highest or lowest set bit
// Ports:
//   vec    [WIDTH]  vector to search
//   mode   [1]      MODE_HI picks the highest set bit, MODE_LO the lowest
//   onehot [WIDTH]  selected bit as one-hot, zero when vec is zero
//   idx    [IDX_W]  binary index of the selected bit, zero when vec is zero
//   any    [1]      vec has at least one bit set
module bitops_prio_pick
  import bitops_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             mode,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // The loop direction is chosen so the last hit wins and is the wanted bit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |vec;
    if (mode == MODE_HI) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          onehot = WIDTH'(1) << i;
          idx    = IDX_W'(i);
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          onehot = WIDTH'(1) << i;
          idx    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/bitops_bit_iter.sv
// rtl/bitops_bit_iter.sv - iterates the set bits of a captured vector, one beat per bit
// Optional feature: define BITOPS_BIT_ITER_ABORT_EN to add the abort input.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   abort      [1]        (BITOPS_BIT_ITER_ABORT_EN only) drop the current vector
//   in_data    [WIDTH]    vector to iterate
//   in_mode    [1]        0 = highest bit first, 1 = lowest bit first
//   in_valid / in_ready   vector handshake, ready only while idle
//   out_onehot [WIDTH]    selected bit as one-hot
//   out_idx    [IDX_W]    index of the selected bit
//   out_found  [1]        0 when the captured vector was all-zero
//   out_last   [1]        final beat for this vector
//   out_valid / out_ready beat handshake
module bitops_bit_iter
  import bitops_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef BITOPS_BIT_ITER_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_found,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem;
  logic             mode_q;
  logic [WIDTH-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             single;
  logic             drop;

  bitops_prio_pick #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_pick (
    .vec   (rem),
    .mode  (mode_q),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // At most one bit set: clearing the lowest set bit leaves nothing.
  assign single = ~|(rem & (rem - WIDTH'(1)));

`ifdef BITOPS_BIT_ITER_ABORT_EN
  assign drop = abort;
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_onehot = '0;
    out_idx    = '0;
    out_found  = 1'b0;
    out_last   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SCAN;
      end
      SCAN: begin
        out_valid  = 1'b1;
        out_onehot = pick_onehot;
        out_idx    = pick_idx;
        out_found  = pick_any;
        out_last   = single;
        if (drop || (out_ready && single)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // An all-zero vector still yields one beat: clearing a zero one-hot is harmless
  // and single is already true, so the first accepted beat ends the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= '0;
      mode_q <= MODE_HI;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem    <= in_data;
            mode_q <= in_mode;
          end
        end
        SCAN: begin
          if (drop) rem <= '0;
          else if (out_ready) rem <= rem & ~pick_onehot;
        end
        default: rem <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bitops_bit_iter.sv
// tb/tb_bitops_bit_iter.sv - scoreboard bench for bitops_bit_iter with directed vectors
module tb_bitops_bit_iter;
  import bitops_pkg::*;

  typedef struct packed {
    logic [7:0] oh;
    logic [2:0] idx;
    logic       found;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_mode = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic [2:0] out_idx;
  logic       out_found;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int    total = 0;
  int    passed = 0;
  beat_t sb[$];

  bitops_bit_iter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef BITOPS_BIT_ITER_ABORT_EN
    .abort     (abort),
`endif
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_onehot(out_onehot),
    .out_idx   (out_idx),
    .out_found (out_found),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push(input int idx, input logic found, input logic last);
    beat_t b;
    b.oh    = found ? (8'h01 << idx) : 8'h00;
    b.idx   = 3'(idx);
    b.found = found;
    b.last  = last;
    sb.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic m);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_send", in_ready, 1);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("first_beat_latency", out_valid, 1);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      tick();
      cyc++;
    end
    check("return_idle", in_ready, 1);
  endtask

  // Monitor: pops on every accepted beat and checks stalled beats stay put.
  initial begin
    beat_t cur, held, exp;
    bit    held_v = 0;
    bit    accepted;
    forever begin
      @(negedge clk);
      cur = {out_onehot, out_idx, out_found, out_last};
      if (rst_n && out_valid) begin
        if (held_v) check("stall_hold", cur, held);
        accepted = out_ready;
`ifdef BITOPS_BIT_ITER_ABORT_EN
        if (abort) accepted = 1'b0;
`endif
        if (accepted) begin
          check("beat_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("beat", cur, exp);
          end
          held_v = 0;
        end else begin
          held   = cur;
          held_v = 1;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  initial begin
    int c;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {out_onehot, out_idx, out_found, out_last}, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // 0xA4 highest first: 7,5,2
    push(7, 1, 0); push(5, 1, 0); push(2, 1, 1);
    send(8'hA4, MODE_HI);
    wait_idle(c);
    check("a4_hi_cycles", c, 3);

    // 0xA4 lowest first, with in_data/in_valid wiggled mid-scan
    push(2, 1, 0); push(5, 1, 0); push(7, 1, 1);
    send(8'hA4, MODE_LO);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_idle(c);
    check("a4_lo_cycles", c + 1, 3);

    // all-zero vector: one empty last beat
    push(0, 0, 1);
    send(8'h00, MODE_HI);
    wait_idle(c);
    check("zero_cycles", c, 1);

    // single bit, lowest first
    push(4, 1, 1);
    send(8'h10, MODE_LO);
    wait_idle(c);
    check("single_cycles", c, 1);

    // 0xFF with out_ready toggling
    for (int i = 7; i >= 0; i--) push(i, 1, i == 0);
    send(8'hFF, MODE_HI);
    c = 0;
    while (!in_ready && c < 200) begin
      tick();
      out_ready = ~out_ready;
      c++;
    end
    check("ff_stall_idle", in_ready, 1);
    out_ready = 1'b1;

    // reset after the second beat of 0xF0
    push(7, 1, 0); push(6, 1, 0);
    send(8'hF0, MODE_HI);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid_drop", out_valid, 0);
    check("rst_mid_outputs", {out_onehot, out_idx, out_found, out_last}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_mid_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_beat_after_reset", out_valid, 0);
    end

`ifdef BITOPS_BIT_ITER_ABORT_EN
    // abort 0x0F after its first beat
    push(3, 1, 0);
    send(8'h0F, MODE_HI);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", in_ready, 1);
    check("abort_no_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_beat_after_abort", out_valid, 0);
    end
`endif

    tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
